// File: rtl/lisnoc_vc_link_arbiter.sv
// lisnoc_vc_link_arbiter
//   Shares one physical flit link between `vchannels` virtual channels.
//   Round-robin arbitration among valid vchannels. In the default build a
//   granted HEADER locks the link to that vchannel until its LAST flit
//   (wormhole). The output flit and its one-hot valid are registered, so a
//   flit appears on the link one cycle after it is accepted.
//
//   Optional feature: define LISNOC_VC_ARB_INTERLEAVE_EN to drop the packet
//   lock. Every accepted flit then re-arbitrates, and flits of different
//   vchannels may interleave on the link.
//
// Ports
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   data_i   in   vchannels*flit_width input flits, vc i at [i*flit_width +: flit_width]
//   valid_i  in   per-vchannel input valid
//   ready_o  out  per-vchannel input ready
//   data_o   out  registered output flit
//   valid_o  out  registered one-hot output valid
//   ready_i  in   per-vchannel downstream ready
module lisnoc_vc_link_arbiter #(
  parameter int vchannels  = 3,
  parameter int flit_width = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [vchannels*flit_width-1:0] data_i,
  input  logic [vchannels-1:0]            valid_i,
  output logic [vchannels-1:0]            ready_o,
  output logic [flit_width-1:0]           data_o,
  output logic [vchannels-1:0]            valid_o,
  input  logic [vchannels-1:0]            ready_i
);

  localparam int PTR_W = $clog2(vchannels);
  localparam logic [PTR_W-1:0] LAST_VC = PTR_W'(vchannels - 1);

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx);
    return (idx == LAST_VC) ? '0 : idx + PTR_W'(1);
  endfunction

  logic [flit_width-1:0] flits [vchannels];
  for (genvar g = 0; g < vchannels; g++) begin : g_split
    assign flits[g] = data_i[g*flit_width +: flit_width];
  end

  logic [vchannels-1:0]  valid_q, valid_d;
  logic [flit_width-1:0] data_q, data_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;

  logic                  load_en;
  logic                  xfer;
  logic [vchannels-1:0]  rr_grant, grant;
  logic [PTR_W-1:0]      rr_idx, grant_idx;
  logic [flit_width-1:0] sel_flit;

  // Round-robin scan starting at ptr_q and wrapping modulo vchannels.
  always_comb begin : rr_scan
    int               widx;
    logic [PTR_W-1:0] sidx;
    logic             found;
    rr_grant = '0;
    rr_idx   = '0;
    widx     = 0;
    sidx     = '0;
    found    = 1'b0;
    for (int off = 0; off < vchannels; off++) begin
      widx = int'(ptr_q) + off;
      if (widx >= vchannels) widx = widx - vchannels;
      sidx = PTR_W'(widx);
      if (!found && valid_i[sidx]) begin
        found          = 1'b1;
        rr_grant[sidx] = 1'b1;
        rr_idx         = sidx;
      end
    end
  end

`ifndef LISNOC_VC_ARB_INTERLEAVE_EN
  localparam logic [1:0] FLIT_HEADER = 2'b01;
  localparam logic [1:0] FLIT_LAST   = 2'b10;

  typedef enum logic {ST_UNLOCKED, ST_LOCKED} state_e;

  state_e               state_q, state_d;
  logic [vchannels-1:0] lock_q, lock_d;
  logic [PTR_W-1:0]     lock_idx;
  logic [1:0]           flit_type;

  always_comb begin : lock_index
    logic [PTR_W-1:0] sidx;
    lock_idx = '0;
    sidx     = '0;
    for (int i = 0; i < vchannels; i++) begin
      sidx = PTR_W'(i);
      if (lock_q[sidx]) lock_idx = sidx;
    end
  end

  // While locked only the owning vchannel may be granted, even when idle.
  always_comb begin
    grant     = rr_grant;
    grant_idx = rr_idx;
    if (state_q == ST_LOCKED) begin
      grant     = lock_q & valid_i;
      grant_idx = lock_idx;
    end
  end
`else
  always_comb begin
    grant     = rr_grant;
    grant_idx = rr_idx;
  end
`endif

  // The output register can take a new flit when empty or being drained.
  assign load_en  = (valid_q == '0) || (|(valid_q & ready_i));
  assign ready_o  = rst_n ? (grant & {vchannels{load_en}}) : '0;
  assign xfer     = |(valid_i & ready_o);
  assign sel_flit = flits[grant_idx];

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (xfer) begin
      valid_d = grant;
      data_d  = sel_flit;
    end else if (|(valid_q & ready_i)) begin
      valid_d = '0;
    end
  end

`ifndef LISNOC_VC_ARB_INTERLEAVE_EN
  assign flit_type = sel_flit[flit_width-1 -: 2];

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      case (state_q)
        ST_UNLOCKED: begin
          if (flit_type == FLIT_HEADER) begin
            state_d = ST_LOCKED;
            lock_d  = grant;
          end else begin
            // SINGLE, or a stray PAYLOAD/LAST forwarded without locking.
            ptr_d = next_ptr(grant_idx);
          end
        end
        ST_LOCKED: begin
          if (flit_type == FLIT_LAST) begin
            state_d = ST_UNLOCKED;
            lock_d  = '0;
            ptr_d   = next_ptr(lock_idx);
          end
        end
        default: state_d = ST_UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_UNLOCKED;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
    end
  end
`else
  always_comb begin
    ptr_d = ptr_q;
    if (xfer) ptr_d = next_ptr(grant_idx);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ptr_q   <= ptr_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: tb/tb_lisnoc_vc_link_arbiter.sv
module tb_lisnoc_vc_link_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [95:0] data_i;
  logic [2:0]  valid_i;
  logic [2:0]  ready_o;
  logic [31:0] data_o;
  logic [2:0]  valid_o;
  logic [2:0]  ready_i = 3'b111;

  lisnoc_vc_link_arbiter #(.vchannels(3), .flit_width(32)) dut (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready_o), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  vld;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] src0[$];
  logic [31:0] src1[$];
  logic [31:0] src2[$];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void expect_flit(input logic [2:0] vld, input logic [31:0] d);
    exp_t e;
    e.vld  = vld;
    e.data = d;
    exp_q.push_back(e);
  endfunction

  // Source driver plus scoreboard: sample transfers mid-cycle, pop what the
  // DUT accepted after the edge, and compare every consumed output flit.
  initial begin
    logic [2:0] acc;
    logic [2:0] cons;
    exp_t       e;
    valid_i = '0;
    data_i  = '0;
    forever begin
      @(negedge clk);
      acc  = valid_i & ready_o;
      cons = valid_o & ready_i;
      if (cons != 3'b000) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard_extra: got valid_o=%b data_o=%h, required no output", valid_o, data_o);
        end else begin
          e = exp_q.pop_front();
          if (valid_o !== e.vld || data_o !== e.data) begin
            n_fail++;
            $display("FAIL scoreboard: got valid_o=%b data_o=%h, required valid_o=%b data_o=%h",
                     valid_o, data_o, e.vld, e.data);
          end
        end
      end
      @(posedge clk);
      #1;
      if (acc[0] && src0.size() != 0) void'(src0.pop_front());
      if (acc[1] && src1.size() != 0) void'(src1.pop_front());
      if (acc[2] && src2.size() != 0) void'(src2.pop_front());
      valid_i[0]     = (src0.size() != 0);
      valid_i[1]     = (src1.size() != 0);
      valid_i[2]     = (src2.size() != 0);
      data_i[31:0]   = (src0.size() != 0) ? src0[0] : 32'h0;
      data_i[63:32]  = (src1.size() != 0) ? src1[0] : 32'h0;
      data_i[95:64]  = (src2.size() != 0) ? src2[0] : 32'h0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic wait_drain(output bit ok);
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    ok = (exp_q.size() == 0);
  endtask

  task automatic test_reset();
    bit ok;
    for (int i = 0; i < 3; i++) expect_flit(3'b001 << i, 32'hC000_0000 | i);
    src0.push_back(32'hC000_0000);
    src1.push_back(32'hC000_0001);
    src2.push_back(32'hC000_0002);
    repeat (3) step();
    @(negedge clk);
    n_checks++;
    if (valid_o !== 3'b000) begin n_fail++; $display("FAIL reset_valid_o: got %b, required 000", valid_o); end
    n_checks++;
    if (data_o !== 32'h0) begin n_fail++; $display("FAIL reset_data_o: got %h, required 00000000", data_o); end
    n_checks++;
    if (ready_o !== 3'b000) begin n_fail++; $display("FAIL reset_ready_o: got %b, required 000", ready_o); end
    step();
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ready_o !== 3'b001) begin n_fail++; $display("FAIL reset_first_grant: got ready_o=%b, required 001", ready_o); end
    wait_drain(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL reset_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_round_robin();
    bit ok;
    int bubbles = 0;
    int t = 0;
    step();
    for (int k = 0; k < 4; k++) begin
      src0.push_back(32'hC000_0000);
      src1.push_back(32'hC000_0001);
      src2.push_back(32'hC000_0002);
      for (int i = 0; i < 3; i++) expect_flit(3'b001 << i, 32'hC000_0000 | i);
    end
    while (valid_o == 3'b000 && t < 20) begin @(negedge clk); t++; end
    for (int k = 0; k < 12; k++) begin
      if (valid_o == 3'b000) bubbles++;
      if (k < 11) @(negedge clk);
    end
    n_checks++;
    if (bubbles != 0) begin n_fail++; $display("FAIL rr_throughput: got %0d bubbles, required 0", bubbles); end
    wait_drain(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rr_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

`ifndef LISNOC_VC_ARB_INTERLEAVE_EN
  task automatic test_wormhole();
    bit ok;
    int bubbles = 0;
    int t = 0;
    step();
    // A lone vc0 single moves the pointer to vc1.
    src0.push_back(32'hC000_00A5);
    expect_flit(3'b001, 32'hC000_00A5);
    wait_drain(ok);
    step();
    src1.push_back(32'h4000_0001);
    src1.push_back(32'h0000_0002);
    src1.push_back(32'h8000_0003);
    src0.push_back(32'hC000_00A0);
    src2.push_back(32'hC000_00A2);
    expect_flit(3'b010, 32'h4000_0001);
    expect_flit(3'b010, 32'h0000_0002);
    expect_flit(3'b010, 32'h8000_0003);
    expect_flit(3'b100, 32'hC000_00A2);
    expect_flit(3'b001, 32'hC000_00A0);
    while (valid_o == 3'b000 && t < 20) begin @(negedge clk); t++; end
    for (int k = 0; k < 5; k++) begin
      if (valid_o == 3'b000) bubbles++;
      if (k < 4) @(negedge clk);
    end
    n_checks++;
    if (bubbles != 0) begin n_fail++; $display("FAIL wormhole_back_to_back: got %0d bubbles, required 0", bubbles); end
    wait_drain(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL wormhole_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_locked_idle();
    bit ok;
    step();
    src0.push_back(32'h4000_00B0);
    expect_flit(3'b001, 32'h4000_00B0);
    step();
    src2.push_back(32'hC000_00B2);
    @(negedge clk);
    n_checks++;
    if (ready_o !== 3'b001) begin n_fail++; $display("FAIL idle_header_grant: got ready_o=%b, required 001", ready_o); end
    step();
    @(negedge clk);
    n_checks++;
    if (ready_o !== 3'b000) begin n_fail++; $display("FAIL idle_gap1_ready: got ready_o=%b, required 000", ready_o); end
    step();
    src0.push_back(32'h8000_00B1);
    expect_flit(3'b001, 32'h8000_00B1);
    expect_flit(3'b100, 32'hC000_00B2);
    @(negedge clk);
    n_checks++;
    if (ready_o !== 3'b000) begin n_fail++; $display("FAIL idle_gap2_ready: got ready_o=%b, required 000", ready_o); end
    n_checks++;
    if (valid_o !== 3'b000) begin n_fail++; $display("FAIL idle_gap_valid: got valid_o=%b, required 000", valid_o); end
    step();
    @(negedge clk);
    n_checks++;
    if (ready_o !== 3'b001) begin n_fail++; $display("FAIL idle_last_accept: got ready_o=%b, required 001", ready_o); end
    wait_drain(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL idle_drain: got %0d pending, required 0", exp_q.size()); end
  endtask
`else
  task automatic test_interleave();
    bit ok;
    step();
    for (int k = 0; k < 3; k++) begin
      logic [31:0] f0;
      logic [31:0] f1;
      logic [1:0]  ty;
      ty = (k == 0) ? 2'b01 : (k == 1) ? 2'b00 : 2'b10;
      f0 = {ty, 30'h10 + 30'(k)};
      f1 = {ty, 30'h20 + 30'(k)};
      src0.push_back(f0);
      src1.push_back(f1);
      expect_flit(3'b001, f0);
      expect_flit(3'b010, f1);
    end
    wait_drain(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL interleave_drain: got %0d pending, required 0", exp_q.size()); end
  endtask
`endif

  task automatic test_backpressure();
    bit ok;
    step();
    ready_i = 3'b110;
    src0.push_back(32'hC000_00D0);
    src1.push_back(32'hC000_00E1);
    expect_flit(3'b001, 32'hC000_00D0);
    expect_flit(3'b010, 32'hC000_00E1);
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (valid_o !== 3'b001 || data_o !== 32'hC000_00D0) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got valid_o=%b data_o=%h, required 001 c00000d0", i, valid_o, data_o);
      end
      n_checks++;
      if (ready_o !== 3'b000) begin n_fail++; $display("FAIL stall_ready[%0d]: got %b, required 000", i, ready_o); end
      if (i < 2) step();
    end
    step();
    ready_i = 3'b111;
    @(negedge clk);
    n_checks++;
    if (ready_o !== 3'b010) begin n_fail++; $display("FAIL stall_release_ready: got %b, required 010", ready_o); end
    wait_drain(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL stall_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_packet();
    bit ok;
    step();
    ready_i = 3'b000;
    src1.push_back(32'h4000_00F1);
    step();
    step();
    @(negedge clk);
    n_checks++;
    if (valid_o !== 3'b010) begin n_fail++; $display("FAIL midrst_loaded: got valid_o=%b, required 010", valid_o); end
    step();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (valid_o !== 3'b000 || data_o !== 32'h0) begin
      n_fail++;
      $display("FAIL midrst_clear: got valid_o=%b data_o=%h, required 000 00000000", valid_o, data_o);
    end
    step();
    rst_n   = 1'b1;
    ready_i = 3'b111;
    src2.push_back(32'hC000_00C2);
    expect_flit(3'b100, 32'hC000_00C2);
    wait_drain(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL midrst_lock_dropped: got %0d pending, required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
`ifndef LISNOC_VC_ARB_INTERLEAVE_EN
    test_wormhole();
    test_locked_idle();
`else
    test_interleave();
`endif
    test_backpressure();
    test_reset_mid_packet();
    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lisnoc_vc_link_arbiter.md
Name: lisnoc_vc_link_arbiter

Overview:
- Shares one physical flit link between `vchannels` virtual channels.
- Each vchannel has its own input flit bus. Several vchannels may be valid in the same cycle.
- Picks one flit per cycle using round-robin order and holds whole packets together (wormhole).
- Drives a registered output link with a one-hot per-vchannel valid. Downstream consumers that need contiguous packets per link can sit directly behind it.

Parameters:
- vchannels, 3, number of virtual channels, ≥2.
- flit_width, 32, flit width in bits. Bits [flit_width-1:flit_width-2] carry the flit type.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- data_i  in  vchannels*flit_width  input flits. Vchannel i occupies [i*flit_width +: flit_width].
- valid_i  in  vchannels  per-vchannel input valid.
- ready_o  out  vchannels  per-vchannel input ready.
- data_o  out  flit_width  registered output flit.
- valid_o  out  vchannels  registered output valid, at most one bit set.
- ready_i  in  vchannels  per-vchannel downstream ready.

Behaviour:
- Flit types come from lisnoc_def.vh: PAYLOAD 2'b00, HEADER 2'b01, LAST 2'b10, SINGLE 2'b11.
- Reset (asynchronous, rst_n=0):
  - valid_o=0, data_o=0, state=UNLOCKED, rr pointer ptr=0, lock register=0.
  - ready_o=0 while rst_n=0.
- Output stage:
  - load_en = (valid_o==0) | |(valid_o & ready_i).
  - An output flit is consumed when valid_o[k] & ready_i[k].
- Grant:
  - g = one-hot, combinational.
  - UNLOCKED: g is the first set bit of valid_i, scanning from ptr upward and wrapping modulo vchannels.
  - LOCKED: g = lock & valid_i.
  - ready_o = g & {vchannels{load_en}}.
  - Input transfer = valid_i[g] & ready_o[g].
- Input transfer:
  - data_o <= selected flit, valid_o <= g, on the next edge.
  - Latency is 1 cycle from input to output.
  - Without an input transfer: if the output flit was consumed, valid_o <= 0; data_o holds its value.
- Full throughput: one flit per cycle when ready_i of the occupied vchannel stays high.
- FSM, updated only on input transfers:
  - UNLOCKED, HEADER → LOCKED, lock <= g.
  - UNLOCKED, SINGLE → stay UNLOCKED, ptr <= index(g)+1 mod vchannels.
  - UNLOCKED, PAYLOAD or LAST (protocol error) → forwarded, stay UNLOCKED, ptr advances as for SINGLE.
  - LOCKED, LAST → UNLOCKED, ptr <= index(lock)+1 mod vchannels.
  - LOCKED, HEADER, PAYLOAD or SINGLE → stay LOCKED.
- While LOCKED, all other vchannels get ready_o=0, even if the locked vchannel is idle (valid low).
- Downstream stall on the occupied vchannel: load_en=0, all ready_o=0, no state change. data_o and valid_o must stay stable until consumed.
- Wrap-around: ptr=vchannels-1 advances to 0.
- Simultaneous output consume and new input transfer in the same cycle: the register is reloaded. No bubble.
- rst_n asserted mid-packet: lock is dropped, and any flit in the output register is discarded.

Optional Feature:
- Macro: LISNOC_VC_ARB_INTERLEAVE_EN.
- Defined:
  - No LOCKED state. Every input transfer re-arbitrates and sets ptr <= index(g)+1, whatever the flit type.
  - Flits of different vchannels may interleave on the link. This is legal because each vchannel has its own downstream buffer.
  - The lock register is removed.
- Undefined: packet-locked behaviour exactly as specified above.

Test Plan:
- Reset: hold rst_n=0 with valid_i=3'b111 → valid_o=0, data_o=0, ready_o=0. First release cycle grants vc0, because ptr=0.
- Round-robin on singles: vc0, vc1, vc2 each offer SINGLE flits 0xC0000000|i continuously, ready_i=3'b111 → valid_o goes 001, 010, 100, 001…, one flit per cycle, data_o matching.
- Wormhole lock: vc1 sends HEADER 0x40000001, PAYLOAD 0x00000002, LAST 0x80000003, while vc0 and vc2 are valid throughout → the three vc1 flits appear back-to-back with valid_o=010, then vc2 is granted next (ptr=2).
- Locked idle: vc0 sends a HEADER, then drops valid for 2 cycles while vc2 is valid → ready_o[2]=0 and valid_o=0 in the gap; vc0's LAST is accepted after the gap.
- Backpressure: ready_i[0]=0 for 3 cycles while valid_o=001 → data_o and valid_o stable, ready_o=000. Delivery resumes the cycle after ready_i[0]=1.
- Interleave (macro defined): vc0 and vc1 each send HEADER/PAYLOAD/LAST simultaneously → valid_o alternates 001/010 per cycle, and each vchannel's flit order is preserved.
